// File: rtl/ascon_dec_ctrl.sv
// ascon_dec_ctrl: ASCON-AEAD128 decryption sequencer for the Permutation_XOR datapath; one round per cycle.
// Blocks are accepted only in the WAIT states. Build macro ASCON_DEC_FAIL_CNT_EN adds fail_cnt_o.
module ascon_dec_ctrl #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8,
    parameter int TAG_W    = 128
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             blk_valid_i,
    input  logic             blk_type_i,
    input  logic             blk_last_i,
    output logic             blk_ready_o,
    output logic             init_p_o,
    output logic [3:0]       round_p_o,
    output logic             enable_p_o,
    output logic             enable_xor_b_o,
    output logic [1:0]       enable_xor_e_o,
    output logic             pt_valid_o,
    input  logic [TAG_W-1:0] tag_calc_i,
    input  logic [TAG_W-1:0] tag_rx_i,
    output logic             done_o,
    output logic             tag_ok_o,
    output logic             err_o,
`ifdef ASCON_DEC_FAIL_CNT_EN
    output logic [7:0]       fail_cnt_o,
`endif
    output logic             busy_o
);

    localparam logic [3:0] RND_LAST = 4'(ROUNDS_A - 1);
    localparam logic [3:0] RND_B0   = 4'(ROUNDS_A - ROUNDS_B);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_AD, S_DSEP, S_PERM_B, S_WAIT_CT, S_FINAL, S_TAG
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic       ad_phase_q, ad_phase_d;
    logic       last_q, last_d;
    logic       tag_ok_q, tag_ok_d;
    logic       err_q, err_d;
    logic       accept;
    logic       tag_match;

    assign accept    = blk_valid_i & blk_ready_o;
    assign tag_match = (tag_calc_i == tag_rx_i);

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q    <= S_IDLE;
            rnd_q      <= '0;
            ad_phase_q <= 1'b0;
            last_q     <= 1'b0;
            tag_ok_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            ad_phase_q <= ad_phase_d;
            last_q     <= last_d;
            tag_ok_q   <= tag_ok_d;
            err_q      <= err_d;
        end
    end

`ifdef ASCON_DEC_FAIL_CNT_EN
    logic [7:0] fail_cnt_q;

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            fail_cnt_q <= '0;
        end else if (state_q == S_TAG && !tag_match && fail_cnt_q != 8'hFF) begin
            fail_cnt_q <= fail_cnt_q + 8'd1;
        end
    end

    assign fail_cnt_o = fail_cnt_q;
`endif

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        ad_phase_d = ad_phase_q;
        last_d     = last_q;
        tag_ok_d   = tag_ok_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_INIT;
                    rnd_d    = '0;
                    tag_ok_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_INIT: begin
                if (rnd_q == RND_LAST) state_d = S_WAIT_AD;
                else                   rnd_d   = rnd_q + 4'd1;
            end
            S_WAIT_AD: begin
                if (accept) begin
                    last_d = blk_last_i;
                    if (!blk_type_i) begin
                        state_d    = S_PERM_B;
                        rnd_d      = RND_B0;
                        ad_phase_d = 1'b1;
                    end else begin
                        // CT with no AD: domain separation first, block continues after it
                        state_d    = S_DSEP;
                        ad_phase_d = 1'b0;
                    end
                end
            end
            S_DSEP: begin
                if (last_q) begin
                    state_d = S_FINAL;
                    rnd_d   = '0;
                end else begin
                    state_d = S_PERM_B;
                    rnd_d   = RND_B0;
                end
            end
            S_PERM_B: begin
                if (rnd_q == RND_LAST) begin
                    if (ad_phase_q && !last_q) state_d = S_WAIT_AD;
                    else                       state_d = S_WAIT_CT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_WAIT_CT: begin
                if (accept) begin
                    ad_phase_d = 1'b0;
                    if (!blk_type_i) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else if (blk_last_i) begin
                        state_d = S_FINAL;
                        rnd_d   = '0;
                    end else begin
                        state_d = S_PERM_B;
                        rnd_d   = RND_B0;
                    end
                end
            end
            S_FINAL: begin
                if (rnd_q == RND_LAST) state_d = S_TAG;
                else                   rnd_d   = rnd_q + 4'd1;
            end
            S_TAG: begin
                tag_ok_d = tag_match;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        blk_ready_o    = 1'b0;
        init_p_o       = 1'b0;
        round_p_o      = '0;
        enable_p_o     = 1'b0;
        enable_xor_b_o = 1'b0;
        enable_xor_e_o = 2'b00;
        pt_valid_o     = 1'b0;
        done_o         = 1'b0;
        unique case (state_q)
            S_INIT: begin
                enable_p_o = 1'b1;
                round_p_o  = rnd_q;
                init_p_o   = (rnd_q == 4'd0);
                if (rnd_q == RND_LAST) enable_xor_e_o = 2'b01;
            end
            S_WAIT_AD, S_WAIT_CT: begin
                blk_ready_o = 1'b1;
                pt_valid_o  = blk_valid_i & blk_type_i;
            end
            S_DSEP: enable_xor_e_o = 2'b11;
            S_PERM_B: begin
                enable_p_o     = 1'b1;
                round_p_o      = rnd_q;
                enable_xor_b_o = (rnd_q == RND_B0);
                if (rnd_q == RND_LAST && ad_phase_q && last_q) enable_xor_e_o = 2'b11;
            end
            S_FINAL: begin
                enable_p_o     = 1'b1;
                round_p_o      = rnd_q;
                enable_xor_b_o = (rnd_q == 4'd0);
                if (rnd_q == RND_LAST) enable_xor_e_o = 2'b10;
            end
            S_TAG: done_o = 1'b1;
            default: ;
        endcase
    end

    // tag_ok_o is valid alongside done_o and held afterwards
    assign tag_ok_o = (state_q == S_TAG) ? tag_match : tag_ok_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ascon_dec_ctrl.sv
// Bench for ascon_dec_ctrl: expected per-cycle trace built from transaction descriptions.
module tb_ascon_dec_ctrl;

    logic         clk = 1'b0;
    logic         resetb_i = 1'b0;
    logic         start_i = 1'b0;
    logic         blk_valid_i = 1'b0;
    logic         blk_type_i = 1'b0;
    logic         blk_last_i = 1'b0;
    logic         blk_ready_o;
    logic         init_p_o;
    logic [3:0]   round_p_o;
    logic         enable_p_o;
    logic         enable_xor_b_o;
    logic [1:0]   enable_xor_e_o;
    logic         pt_valid_o;
    logic [127:0] tag_calc_i = '0;
    logic [127:0] tag_rx_i = '0;
    logic         done_o;
    logic         tag_ok_o;
    logic         err_o;
    logic         busy_o;
`ifdef ASCON_DEC_FAIL_CNT_EN
    logic [7:0]   fail_cnt_o;
    int           m_fail = 0;
`endif

    always #5 clk = ~clk;

    ascon_dec_ctrl dut (
        .clock_i        (clk),
        .resetb_i       (resetb_i),
        .start_i        (start_i),
        .blk_valid_i    (blk_valid_i),
        .blk_type_i     (blk_type_i),
        .blk_last_i     (blk_last_i),
        .blk_ready_o    (blk_ready_o),
        .init_p_o       (init_p_o),
        .round_p_o      (round_p_o),
        .enable_p_o     (enable_p_o),
        .enable_xor_b_o (enable_xor_b_o),
        .enable_xor_e_o (enable_xor_e_o),
        .pt_valid_o     (pt_valid_o),
        .tag_calc_i     (tag_calc_i),
        .tag_rx_i       (tag_rx_i),
        .done_o         (done_o),
        .tag_ok_o       (tag_ok_o),
        .err_o          (err_o),
`ifdef ASCON_DEC_FAIL_CNT_EN
        .fail_cnt_o     (fail_cnt_o),
`endif
        .busy_o         (busy_o)
    );

    // One entry per clock cycle: what to drive and what the outputs must be.
    typedef struct {
        logic       st, vld, typ, last, rst;
        logic       rdy, init, en, xb, pt, done, ok, err, busy;
        logic [1:0] xe;
        logic [3:0] rnd;
        logic       chk_rnd;
    } step_t;

    step_t tr[$];
    logic  m_ok = 1'b0;
    logic  m_err = 1'b0;
    int    fin6_idx = 0;
    int    gap_max = 0;
    int    nchk = 0;
    int    npass = 0;
    int    nfail = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic step_t blank(logic busy);
        step_t s;
        s = '{default: 1'b0, xe: 2'b00, rnd: 4'd0};
        s.busy = busy;
        s.ok   = m_ok;
        s.err  = m_err;
        return s;
    endfunction

    task automatic add_perm(int r0, logic [1:0] xe_last, logic xb_first, logic init_first);
        step_t s;
        for (int r = r0; r <= 11; r++) begin
            s = blank(1'b1);
            s.en = 1'b1;
            s.chk_rnd = 1'b1;
            s.rnd = 4'(r);
            s.xb = xb_first && (r == r0);
            s.init = init_first && (r == r0);
            s.xe = (r == 11) ? xe_last : 2'b00;
            tr.push_back(s);
        end
    endtask

    task automatic add_block(logic typ, logic last);
        step_t s;
        int gap;
        gap = $urandom_range(0, gap_max);
        for (int g = 0; g < gap; g++) begin
            s = blank(1'b1);
            s.rdy = 1'b1;
            tr.push_back(s);
        end
        s = blank(1'b1);
        s.rdy = 1'b1;
        s.vld = 1'b1;
        s.typ = typ;
        s.last = last;
        s.pt = typ;
        tr.push_back(s);
    endtask

    task automatic add_idle(int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s = blank(1'b0);
            s.chk_rnd = 1'b1;
            tr.push_back(s);
        end
    endtask

    // err_ct >= 0: an AD block is presented after CT number err_ct.
    task automatic build(int n_ad, int n_ct, logic match, int err_ct);
        step_t s;
        s = blank(1'b0);
        s.st = 1'b1;
        tr.push_back(s);
        m_ok = 1'b0;
        m_err = 1'b0;
        add_perm(0, 2'b01, 1'b0, 1'b1);
        for (int i = 0; i < n_ad; i++) begin
            add_block(1'b0, i == n_ad - 1);
            add_perm(4, (i == n_ad - 1) ? 2'b11 : 2'b00, 1'b1, 1'b0);
        end
        for (int j = 0; j < n_ct; j++) begin
            add_block(1'b1, j == n_ct - 1);
            if (n_ad == 0 && j == 0) begin
                s = blank(1'b1);
                s.xe = 2'b11;
                tr.push_back(s);
            end
            if (j != n_ct - 1) add_perm(4, 2'b00, 1'b1, 1'b0);
            if (j == err_ct) begin
                add_block(1'b0, 1'($urandom));
                m_err = 1'b1;
                add_idle(3);
                return;
            end
        end
        fin6_idx = tr.size() + 6;
        add_perm(0, 2'b10, 1'b1, 1'b0);
        s = blank(1'b1);
        s.done = 1'b1;
        s.ok = match;
        tr.push_back(s);
        m_ok = match;
`ifdef ASCON_DEC_FAIL_CNT_EN
        if (!match && m_fail < 255) m_fail++;
`endif
        add_idle(2);
    endtask

    task automatic run_trace(string name);
        step_t s;
        for (int k = 0; k < tr.size(); k++) begin
            s = tr[k];
            @(negedge clk);
            resetb_i = ~s.rst;
            start_i = s.st | (s.busy & 1'($urandom));
            if (s.rdy) begin
                blk_valid_i = s.vld;
                blk_type_i = s.vld ? s.typ : 1'($urandom);
                blk_last_i = s.vld ? s.last : 1'($urandom);
            end else begin
                blk_valid_i = 1'($urandom);
                blk_type_i = 1'($urandom);
                blk_last_i = 1'($urandom);
            end
            #1;
            check($sformatf("%s ctl[%0d]", name, k),
                  32'({blk_ready_o, init_p_o, enable_p_o, enable_xor_b_o, enable_xor_e_o,
                       pt_valid_o, done_o, tag_ok_o, err_o, busy_o}),
                  32'({s.rdy, s.init, s.en, s.xb, s.xe, s.pt, s.done, s.ok, s.err, s.busy}));
            if (s.chk_rnd) check($sformatf("%s round[%0d]", name, k), 32'(round_p_o), 32'(s.rnd));
        end
        tr.delete();
        resetb_i = 1'b1;
`ifdef ASCON_DEC_FAIL_CNT_EN
        check({name, " fail_cnt"}, 32'(fail_cnt_o), 32'(m_fail));
`endif
    endtask

    task automatic set_tags(logic match);
        tag_calc_i = {$urandom, $urandom, $urandom, $urandom};
        tag_rx_i = match ? tag_calc_i : tag_calc_i ^ (128'(1) << $urandom_range(0, 127));
    endtask

    initial begin
        logic m;
        // Reset held for two cycles
        resetb_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset ctl", 32'({blk_ready_o, init_p_o, enable_p_o, enable_xor_b_o, enable_xor_e_o,
                                pt_valid_o, done_o, tag_ok_o, err_o, busy_o}), 32'd0);
        check("reset round", 32'(round_p_o), 32'd0);
        resetb_i = 1'b1;

        // One AD, one CT, matching tags, back-to-back blocks
        gap_max = 0;
        tag_calc_i = 128'h0123456789ABCDEF0123456789ABCDEF;
        tag_rx_i = tag_calc_i;
        build(1, 1, 1'b1, -1);
        run_trace("basic");

        // No AD, three CT blocks, tags differ in bit 0
        gap_max = 2;
        tag_rx_i = tag_calc_i ^ 128'd1;
        build(0, 3, 1'b0, -1);
        run_trace("no_ad");

        // AD presented after the first CT block
        build($urandom_range(0, 1), 3, 1'b1, 0);
        run_trace("ad_after_ct");

        // Reset during FINAL round 6, then a clean run
        tag_rx_i = tag_calc_i;
        build(1, 2, 1'b1, -1);
        while (tr.size() > fin6_idx + 1) void'(tr.pop_back());
        tr[fin6_idx].rst = 1'b1;
        m_ok = 1'b0;
        m_err = 1'b0;
        add_idle(3);
        run_trace("mid_reset");
        build(2, 1, 1'b1, -1);
        run_trace("after_reset");

        // Randomized transactions
        for (int t = 0; t < 20; t++) begin
            m = 1'($urandom);
            set_tags(m);
            build($urandom_range(0, 3), $urandom_range(1, 3), m, -1);
            run_trace($sformatf("rand%0d", t));
        end

`ifdef ASCON_DEC_FAIL_CNT_EN
        gap_max = 0;
        for (int t = 0; t < 257; t++) begin
            set_tags(1'b0);
            build(0, 1, 1'b0, -1);
            run_trace("fail_cnt_run");
        end
        check("fail_cnt saturated", 32'(fail_cnt_o), 32'h0000_00FF);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
